// File: rtl/float_discriminant_distributor.sv
// Round-robin distributor over N_ENG binary64 discriminant engines (D = b*b - 4*a*c).
// Results are delivered in acceptance order through a valid/ready handshake.

module float_discriminant_engine #(
  parameter int FLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            arg_vld,
  input  logic [FLEN-1:0] a,
  input  logic [FLEN-1:0] b,
  input  logic [FLEN-1:0] c,
  output logic            res_vld,
  output logic [FLEN-1:0] res,
  output logic            res_negative,
  output logic            err
);
  // Arithmetic is binary64 with round-to-nearest-even; subnormals are flushed to zero.
  function automatic logic is_special(input logic [63:0] x);
    return (x[62:52] == 11'h7FF);
  endfunction

  function automatic logic [5:0] lzc56(input logic [55:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 56; i++) begin
      if (v[i]) n = 6'(55 - i);
    end
    return n;
  endfunction

  function automatic logic [63:0] fmul(input logic [63:0] x, input logic [63:0] y, input logic [1:0] eadj);
    logic               s;
    logic [105:0]       p;
    logic [52:0]        m;
    logic               g;
    logic               st;
    logic [53:0]        mr;
    logic signed [13:0] e;
    logic [63:0]        r;
    s = x[63] ^ y[63];
    p = {53'd0, 1'b1, x[51:0]} * {53'd0, 1'b1, y[51:0]};
    e = $signed({3'b000, x[62:52]}) + $signed({3'b000, y[62:52]}) - 14'sd1023 + $signed({12'd0, eadj});
    if (p[105]) begin
      m  = p[105:53];
      g  = p[52];
      st = |p[51:0];
      e  = e + 14'sd1;
    end else begin
      m  = p[104:52];
      g  = p[51];
      st = |p[50:0];
    end
    mr = {1'b0, m} + {53'd0, (g & (st | m[0]))};
    if (mr[53]) begin
      mr = mr >> 1;
      e  = e + 14'sd1;
    end else begin
      mr = mr;
    end
    if (is_special(x) || is_special(y)) begin
      if ((x[51:0] != 52'd0 && is_special(x)) || (y[51:0] != 52'd0 && is_special(y)) ||
          x[62:52] == 11'd0 || y[62:52] == 11'd0)
        r = 64'h7FF8_0000_0000_0000;
      else
        r = {s, 11'h7FF, 52'd0};
    end else if (x[62:52] == 11'd0 || y[62:52] == 11'd0) begin
      r = {s, 63'd0};
    end else if (e >= 14'sd2047) begin
      r = {s, 11'h7FF, 52'd0};
    end else if (e <= 14'sd0) begin
      r = {s, 63'd0};
    end else begin
      r = {s, e[10:0], mr[51:0]};
    end
    return r;
  endfunction

  function automatic logic [63:0] fadd(input logic [63:0] x, input logic [63:0] y);
    logic [63:0]        xn, yn, hi, lo, r;
    logic [10:0]        d;
    logic [5:0]         dc;
    logic [55:0]        ma, mb, mbs, m;
    logic [111:0]       t;
    logic [56:0]        sum;
    logic [53:0]        mr;
    logic signed [13:0] e;
    xn = (x[62:52] == 11'd0) ? {x[63], 63'd0} : x;
    yn = (y[62:52] == 11'd0) ? {y[63], 63'd0} : y;
    if (xn[62:0] >= yn[62:0]) begin
      hi = xn;
      lo = yn;
    end else begin
      hi = yn;
      lo = xn;
    end
    ma  = {1'b1, hi[51:0], 3'b000};
    mb  = {1'b1, lo[51:0], 3'b000};
    d   = hi[62:52] - lo[62:52];
    dc  = (d > 11'd60) ? 6'd60 : d[5:0];
    t   = {mb, 56'd0} >> dc;
    mbs = t[111:56] | {55'd0, |t[55:0]};
    e   = $signed({3'b000, hi[62:52]});
    // Three guard bits below the mantissa keep the single-step renormalisation exact.
    if (hi[63] == lo[63]) begin
      sum = {1'b0, ma} + {1'b0, mbs};
      if (sum[56]) begin
        m = sum[56:1] | {55'd0, sum[0]};
        e = e + 14'sd1;
      end else begin
        m = sum[55:0];
      end
    end else begin
      sum = 57'd0;
      m   = ma - mbs;
      e   = e - $signed({8'd0, lzc56(m)});
      m   = m << lzc56(m);
    end
    mr = {1'b0, m[55:3]} + {53'd0, (m[2] & (m[1] | m[0] | m[3]))};
    if (mr[53]) begin
      mr = mr >> 1;
      e  = e + 14'sd1;
    end else begin
      mr = mr;
    end
    if (is_special(hi)) begin
      if (hi[51:0] != 52'd0 || (is_special(lo) && (lo[51:0] != 52'd0 || hi[63] != lo[63])))
        r = 64'h7FF8_0000_0000_0000;
      else
        r = hi;
    end else if (lo[62:0] == 63'd0) begin
      r = (hi[62:0] == 63'd0) ? {(hi[63] & lo[63]), 63'd0} : hi;
    end else if (hi[63] != lo[63] && hi[62:0] == lo[62:0]) begin
      r = 64'd0;
    end else if (e >= 14'sd2047) begin
      r = {hi[63], 11'h7FF, 52'd0};
    end else if (e <= 14'sd0) begin
      r = {hi[63], 63'd0};
    end else begin
      r = {hi[63], e[10:0], mr[51:0]};
    end
    return r;
  endfunction

  logic            v1_q, v1_d, vld_q, vld_d, e1_q, e1_d, err_q, err_d;
  logic [FLEN-1:0] bb_q, bb_d, ac4_q, ac4_d, res_q, res_d;

  // Stage 1 forms b*b and 4*a*c; stage 2 subtracts and flags any non-finite value.
  always_comb begin
    v1_d  = arg_vld;
    vld_d = v1_q;
    if (arg_vld) begin
      bb_d  = fmul(b, b, 2'd0);
      ac4_d = fmul(a, c, 2'd2);
      e1_d  = is_special(a) | is_special(b) | is_special(c) | is_special(bb_d) | is_special(ac4_d);
    end else begin
      bb_d  = bb_q;
      ac4_d = ac4_q;
      e1_d  = e1_q;
    end
    if (v1_q) begin
      res_d = fadd(bb_q, {~ac4_q[63], ac4_q[62:0]});
      err_d = e1_q | is_special(res_d);
    end else begin
      res_d = res_q;
      err_d = err_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q  <= 1'b0;
      vld_q <= 1'b0;
      e1_q  <= 1'b0;
      err_q <= 1'b0;
      bb_q  <= '0;
      ac4_q <= '0;
      res_q <= '0;
    end else begin
      v1_q  <= v1_d;
      vld_q <= vld_d;
      e1_q  <= e1_d;
      err_q <= err_d;
      bb_q  <= bb_d;
      ac4_q <= ac4_d;
      res_q <= res_d;
    end
  end

  assign res_vld      = vld_q;
  assign res          = res_q;
  assign res_negative = res_q[FLEN-1];
  assign err          = err_q;
endmodule

module float_discriminant_distributor #(
  parameter int FLEN  = 64,
  parameter int N_ENG = 4,
  parameter int CNT_W = $clog2(N_ENG + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [FLEN-1:0]  a,
  input  logic [FLEN-1:0]  b,
  input  logic [FLEN-1:0]  c,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [FLEN-1:0]  res,
  output logic             res_negative,
  output logic             err,
  output logic             busy,
  output logic [CNT_W-1:0] occupancy
);
  localparam int PW = (N_ENG > 1) ? $clog2(N_ENG) : 1;
  localparam logic [PW-1:0] LAST = PW'(N_ENG - 1);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2} eng_st_e;

  eng_st_e         st_q [N_ENG];
  eng_st_e         st_d [N_ENG];
  logic [FLEN-1:0] slot_res_q [N_ENG];
  logic [FLEN-1:0] slot_res_d [N_ENG];
  logic            slot_neg_q [N_ENG];
  logic            slot_neg_d [N_ENG];
  logic            slot_err_q [N_ENG];
  logic            slot_err_d [N_ENG];
  logic [PW-1:0]   dp_q, dp_d, rp_q, rp_d;
  logic [CNT_W-1:0] occ_q, occ_d;

  logic            eng_go  [N_ENG];
  logic            eng_vld [N_ENG];
  logic [FLEN-1:0] eng_res [N_ENG];
  logic            eng_neg [N_ENG];
  logic            eng_err [N_ENG];
  logic            eng_reset;
  logic            accept, deliver;

  assign eng_reset    = ~rst;
  assign arg_rdy      = rst && (st_q[dp_q] == ST_IDLE);
  assign res_vld      = (st_q[rp_q] == ST_DONE);
  assign res          = slot_res_q[rp_q];
  assign res_negative = slot_neg_q[rp_q];
  assign err          = slot_err_q[rp_q];
  assign occupancy    = occ_q;
  assign accept       = arg_vld && arg_rdy;
  assign deliver      = res_vld && res_rdy;

  for (genvar g = 0; g < N_ENG; g++) begin : g_eng
    float_discriminant_engine #(.FLEN(FLEN)) u_eng (
      .clk          (clk),
      .reset        (eng_reset),
      .arg_vld      (eng_go[g]),
      .a            (a),
      .b            (b),
      .c            (c),
      .res_vld      (eng_vld[g]),
      .res          (eng_res[g]),
      .res_negative (eng_neg[g]),
      .err          (eng_err[g])
    );
  end

  // Pointer rotation, occupancy and per-engine IDLE -> RUN -> DONE sequencing.
  always_comb begin
    dp_d  = accept  ? ((dp_q == LAST) ? '0 : dp_q + 1'b1) : dp_q;
    rp_d  = deliver ? ((rp_q == LAST) ? '0 : rp_q + 1'b1) : rp_q;
    case ({accept, deliver})
      2'b10:   occ_d = occ_q + CNT_W'(1);
      2'b01:   occ_d = occ_q - CNT_W'(1);
      default: occ_d = occ_q;
    endcase
    busy = 1'b0;
    for (int i = 0; i < N_ENG; i++) begin
      st_d[i]       = st_q[i];
      slot_res_d[i] = slot_res_q[i];
      slot_neg_d[i] = slot_neg_q[i];
      slot_err_d[i] = slot_err_q[i];
      eng_go[i]     = accept && (dp_q == PW'(i));
      busy          = busy | (st_q[i] != ST_IDLE);
      case (st_q[i])
        ST_IDLE: begin
          if (eng_go[i]) st_d[i] = ST_RUN;
          else           st_d[i] = ST_IDLE;
        end
        ST_RUN: begin
          if (eng_vld[i]) begin
            st_d[i]       = ST_DONE;
            slot_res_d[i] = eng_res[i];
            slot_neg_d[i] = eng_neg[i];
            slot_err_d[i] = eng_err[i];
          end else begin
            st_d[i] = ST_RUN;
          end
        end
        ST_DONE: begin
          if (deliver && rp_q == PW'(i)) st_d[i] = ST_IDLE;
          else                           st_d[i] = ST_DONE;
        end
        default: st_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      dp_q  <= '0;
      rp_q  <= '0;
      occ_q <= '0;
      for (int i = 0; i < N_ENG; i++) begin
        st_q[i]       <= ST_IDLE;
        slot_res_q[i] <= '0;
        slot_neg_q[i] <= 1'b0;
        slot_err_q[i] <= 1'b0;
      end
    end else begin
      dp_q  <= dp_d;
      rp_q  <= rp_d;
      occ_q <= occ_d;
      for (int i = 0; i < N_ENG; i++) begin
        st_q[i]       <= st_d[i];
        slot_res_q[i] <= slot_res_d[i];
        slot_neg_q[i] <= slot_neg_d[i];
        slot_err_q[i] <= slot_err_d[i];
      end
    end
  end
endmodule

// File: tb/tb_float_discriminant_distributor.sv
// Self-checking bench: constant vector table, hand-written corner sequences and a
// random stream scored against a real-arithmetic reference model.
module tb_float_discriminant_distributor;
  localparam int N_ENG = 4;
  localparam int CNT_W = $clog2(N_ENG + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             arg_vld, arg_rdy, res_vld, res_rdy, res_negative, err, busy;
  logic [63:0]      a, b, c, res;
  logic [CNT_W-1:0] occupancy;

  float_discriminant_distributor #(.FLEN(64), .N_ENG(N_ENG)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .res_negative(res_negative),
    .err(err), .busy(busy), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b, c, res;
    logic        neg, err;
  } vec_t;

  vec_t  pend_q[$];
  vec_t  exp_q[$];
  vec_t  tbl[8];
  int    errors = 0;
  int    checks = 0;
  int    rdy_mode = 1;  // 0 hold off, 1 always ready, 2 random
  string cur_tag = "init";

  localparam logic [63:0] F0 = 64'h0000_0000_0000_0000, F1 = 64'h3FF0_0000_0000_0000,
    F2 = 64'h4000_0000_0000_0000, F3 = 64'h4008_0000_0000_0000, F4 = 64'h4010_0000_0000_0000,
    F5 = 64'h4014_0000_0000_0000, F6 = 64'h4018_0000_0000_0000, FH = 64'h3FE0_0000_0000_0000,
    FINF = 64'h7FF0_0000_0000_0000, FM3 = 64'hC008_0000_0000_0000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t model(input logic [63:0] va, input logic [63:0] vb, input logic [63:0] vc);
    vec_t v;
    real  ra, rb, rc, bb, ac4, d;
    ra  = $bitstoreal(va);
    rb  = $bitstoreal(vb);
    rc  = $bitstoreal(vc);
    bb  = rb * rb;
    ac4 = 4.0 * ra;
    ac4 = ac4 * rc;
    d   = bb - ac4;
    v.a = va; v.b = vb; v.c = vc;
    v.res = $realtobits(d);
    v.neg = v.res[63];
    v.err = 1'b0;
    return v;
  endfunction

  function automatic logic [63:0] rnd_f();
    logic [63:0] v;
    v[63]    = 1'($urandom_range(0, 1));
    v[62:52] = 11'(1003 + $urandom_range(0, 40));
    v[51:20] = $urandom;
    v[19:0]  = 20'($urandom);
    return v;
  endfunction

  // One clock cycle: drive at negedge, score the handshakes that the next posedge will take.
  task automatic step();
    vec_t e;
    @(negedge clk);
    if (pend_q.size() > 0) begin
      arg_vld = 1'b1; a = pend_q[0].a; b = pend_q[0].b; c = pend_q[0].c;
    end else begin
      arg_vld = 1'b0;
    end
    res_rdy = (rdy_mode == 1) ? 1'b1 : (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    chk({cur_tag, "_occ"}, 64'(occupancy), 64'(exp_q.size()));
    if (exp_q.size() == 0) begin
      chk({cur_tag, "_empty_vld"}, 64'(res_vld), 64'd0);
      chk({cur_tag, "_empty_busy"}, 64'(busy), 64'd0);
    end
    if (res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s_spurious actual=res_vld required=none res=%h", cur_tag, res);
      end else begin
        e = exp_q.pop_front();
        chk({cur_tag, "_res"}, res, e.res);
        chk({cur_tag, "_neg"}, 64'(res_negative), 64'(e.neg));
        chk({cur_tag, "_err"}, 64'(err), 64'(e.err));
      end
    end
    if (arg_vld && arg_rdy) exp_q.push_back(pend_q.pop_front());
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (pend_q.size() > 0 || exp_q.size() > 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=%0d_outstanding required=0", cur_tag, pend_q.size() + exp_q.size());
      pend_q.delete();
      exp_q.delete();
    end
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{a: F1, b: F4, c: F3, res: F4,  neg: 1'b0, err: 1'b0};
    tbl[1] = '{a: F1, b: F1, c: F1, res: FM3, neg: 1'b1, err: 1'b0};
    tbl[2] = '{a: F1, b: FINF, c: F1, res: FINF, neg: 1'b0, err: 1'b1};
    tbl[3] = '{a: F1, b: F3, c: F1, res: 64'h4014_0000_0000_0000, neg: 1'b0, err: 1'b0};
    tbl[4] = '{a: F1, b: F2, c: F1, res: F0, neg: 1'b0, err: 1'b0};
    tbl[5] = '{a: F2, b: F3, c: F1, res: F1, neg: 1'b0, err: 1'b0};
    tbl[6] = '{a: FH, b: F1, c: FH, res: F0, neg: 1'b0, err: 1'b0};
    tbl[7] = '{a: F0, b: F5, c: F3, res: 64'h4039_0000_0000_0000, neg: 1'b0, err: 1'b0};

    rst = 1'b0; arg_vld = 1'b0; res_rdy = 1'b0; a = F0; b = F0; c = F0;
    repeat (3) @(posedge clk);
    #1;
    cur_tag = "reset";
    chk("reset_arg_rdy", 64'(arg_rdy), 64'd0);
    chk("reset_res_vld", 64'(res_vld), 64'd0);
    chk("reset_res", res, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Table vectors, one job at a time, then all back to back (err mid-stream).
    rdy_mode = 1;
    for (int i = 0; i < 8; i++) begin
      cur_tag = $sformatf("tbl%0d", i);
      pend_q.push_back(tbl[i]);
      drain(40);
    end
    cur_tag = "tbl_batch";
    for (int i = 0; i < 8; i++) pend_q.push_back(tbl[i]);
    drain(100);
    @(negedge clk); #1;
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_occ", 64'(occupancy), 64'd0);

    // Full and backpressure.
    cur_tag = "full";
    rdy_mode = 0;
    for (int k = 1; k <= 6; k++) begin
      v = '{a: F0, b: $realtobits(real'(k)), c: F0, res: $realtobits(real'(k * k)), neg: 1'b0, err: 1'b0};
      pend_q.push_back(v);
    end
    repeat (15) step();
    chk("full_accepted", 64'(exp_q.size()), 64'd4);
    @(negedge clk); #1;
    chk("full_arg_rdy", 64'(arg_rdy), 64'd0);
    chk("full_occ", 64'(occupancy), 64'(N_ENG));
    chk("full_res_hold", res, 64'h3FF0_0000_0000_0000);
    rdy_mode = 1;
    drain(60);

    // Reset with three jobs outstanding.
    cur_tag = "midrst";
    rdy_mode = 0;
    pend_q.push_back(tbl[0]); pend_q.push_back(tbl[1]); pend_q.push_back(tbl[5]);
    repeat (10) step();
    chk("midrst_accepted", 64'(exp_q.size()), 64'd3);
    @(negedge clk);
    rst = 1'b0; arg_vld = 1'b0;
    @(posedge clk); #1;
    chk("midrst_arg_rdy", 64'(arg_rdy), 64'd0);
    chk("midrst_res_vld", 64'(res_vld), 64'd0);
    chk("midrst_res", res, 64'd0);
    chk("midrst_neg", 64'(res_negative), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_occ", 64'(occupancy), 64'd0);
    exp_q.delete();
    pend_q.delete();
    @(negedge clk);
    rst = 1'b1;
    rdy_mode = 1;
    repeat (8) step();
    cur_tag = "postrst";
    pend_q.push_back(tbl[1]);
    drain(40);

    // Random stream against the reference model, with exact-cancellation cases mixed in.
    cur_tag = "rand";
    rdy_mode = 2;
    for (int k = 0; k < 200; k++) begin
      logic [63:0] ra, rb, rc;
      ra = rnd_f(); rb = rnd_f(); rc = rnd_f();
      if ($urandom_range(0, 9) == 0) begin
        rc = ra;
        rb = {ra[63], ra[62:52] + 11'd1, ra[51:0]};
      end
      pend_q.push_back(model(ra, rb, rc));
    end
    drain(5000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
